// File: rtl/ilog_pkg.sv
// Shared types and constants for the integer-log sequencer and its operand FIFO.
package ilog_pkg;

  localparam int ILOG_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_BASE = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef struct packed {
    logic [ILOG_W-1:0] c;
    logic [ILOG_W-1:0] j;
  } operand_t;

endpackage

// File: rtl/ilog_op_fifo.sv
// DEPTH-entry synchronous FIFO for {c, j} operand pairs; head is read combinationally.
module ilog_op_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr;
  logic             rd;

  // A pop frees the slot being written, so a full FIFO may push and pop together.
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr, rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ilog_sequencer.sv
// Front-end for the integer-log engine: buffers operand pairs, runs one job at a time,
// guards against non-terminating bases and hung engines, and streams results out.
module ilog_sequencer
  import ilog_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int TMO   = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_j,
  output logic         eng_start,
  output logic [W-1:0] eng_c,
  output logic [W-1:0] eng_j,
  input  logic         eng_done,
  input  logic [W-1:0] eng_g,
  output logic         eng_clr,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_g,
  output logic [1:0]   res_err,
  output logic         busy
);

  localparam int            TW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TMO - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [W-1:0]  MIN_BASE = W'(2);

  state_t           state;
  state_t           state_nxt;
  logic             ready_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [2*W-1:0]   head;
  logic [W-1:0]     head_c;
  logic [W-1:0]     head_j;
  logic             dispatch;
  logic             bad_base;
  logic             done_now;
  logic             tmo_now;
  logic [TW-1:0]    timer;

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign in_ready = ready_q && !full;
  assign push     = in_valid && in_ready;
  assign pop      = dispatch;
  assign head_c   = head[2*W-1:W];
  assign head_j   = head[W-1:0];

  ilog_op_fifo #(
    .WIDTH (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_c, in_j}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign dispatch = (state == IDLE) && !empty && !res_valid;
  assign bad_base = (head_c < MIN_BASE);
  assign done_now = (state == WAIT) && eng_done;
  assign tmo_now  = (state == WAIT) && !eng_done && (timer == TMR_LAST);
  assign busy     = (state != IDLE) || !empty || res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Done is ignored during ISSUE; DRAIN waits for a lingering done to fall before reuse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dispatch && !bad_base) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done_now || tmo_now) state_nxt = DRAIN;
      DRAIN:   if (!eng_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    eng_start = (state == ISSUE) || (state == WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_c   <= '0;
      eng_j   <= '0;
      timer   <= '0;
      eng_clr <= 1'b0;
    end else begin
      eng_clr <= done_now || tmo_now;
      if (dispatch && !bad_base) begin
        eng_c <= head_c;
        eng_j <= head_j;
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + TMR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_g     <= '0;
      res_err   <= ERR_OK;
    end else if (dispatch && bad_base) begin
      res_valid <= 1'b1;
      res_g     <= '0;
      res_err   <= ERR_BASE;
    end else if (done_now) begin
      res_valid <= 1'b1;
      res_g     <= eng_g;
      res_err   <= ERR_OK;
    end else if (tmo_now) begin
      res_valid <= 1'b1;
      res_g     <= '0;
      res_err   <= ERR_TMO;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ilog_sequencer.sv
// Self-checking bench: engine stub, queue-based result model, directed scenarios, random traffic.
module tb_ilog_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_c;
  logic [15:0] in_j;
  logic        eng_start;
  logic [15:0] eng_c;
  logic [15:0] eng_j;
  logic        eng_done;
  logic [15:0] eng_g;
  logic        eng_clr;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_g;
  logic [1:0]  res_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 2;
  int linger   = 0;
  bit hang     = 0;
  bit rnd_rdy  = 0;
  bit rnd_bit  = 1;
  bit rdy_set  = 1;
  int start_cycles = 0;
  int clr_pulses   = 0;
  bit prev_clr     = 0;

  typedef struct {
    logic [15:0] c;
    logic [15:0] j;
    logic [15:0] g;
    logic [1:0]  err;
  } exp_t;
  exp_t exp_q[$];

  assign res_ready = rnd_rdy ? rnd_bit : rdy_set;

  ilog_sequencer #(.W(16), .DEPTH(4), .TMO(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .in_j      (in_j),
    .eng_start (eng_start),
    .eng_c     (eng_c),
    .eng_j     (eng_j),
    .eng_done  (eng_done),
    .eng_g     (eng_g),
    .eng_clr   (eng_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_g     (res_g),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic int ref_g(input int c, input int j);
    longint t = c;
    int g = 0;
    while (t < j) begin
      t = t * c;
      g++;
    end
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Engine stub: done after lat start cycles, optional hang, done lingers linger cycles past clr.
  int cnt, lcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done <= 1'b0;
      eng_g    <= '0;
      cnt      <= 0;
      lcnt     <= 0;
    end else if (eng_clr) begin
      cnt <= 0;
      if (linger == 0) eng_done <= 1'b0;
      else             lcnt <= linger;
    end else if (lcnt != 0) begin
      lcnt <= lcnt - 1;
      if (lcnt == 1) eng_done <= 1'b0;
    end else if (eng_start && !eng_done && !hang) begin
      cnt <= cnt + 1;
      if (cnt + 1 >= lat) begin
        eng_done <= 1'b1;
        eng_g    <= 16'(ref_g(int'(eng_c), int'(eng_j)));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: record accepted pushes, check issued operands and every valid result cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_clr = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        e.c = in_c;
        e.j = in_j;
        if (in_c < 2)  begin e.g = '0; e.err = 2'b01; end
        else if (hang) begin e.g = '0; e.err = 2'b10; end
        else           begin e.g = 16'(ref_g(int'(in_c), int'(in_j))); e.err = 2'b00; end
        exp_q.push_back(e);
      end
      if (eng_start) begin
        start_cycles++;
        chk("eng_job_known", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("eng_c", 32'(eng_c), 32'(exp_q[0].c));
          chk("eng_j", 32'(eng_j), 32'(exp_q[0].j));
        end
      end
      if (res_valid) begin
        chk("res_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("res_g", 32'(res_g), 32'(exp_q[0].g));
          chk("res_err", 32'(res_err), 32'(exp_q[0].err));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      if (eng_clr) begin
        chk("clr_one_cycle", 32'(prev_clr), 32'd0);
        if (!prev_clr) clr_pulses++;
      end
      prev_clr = eng_clr;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] c, input logic [15:0] j, input int budget, output bit ok);
    ok = 1'b0;
    in_c = c;
    in_j = j;
    in_valid = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // Cycles from the push cycle to the cycle where res_valid is first high.
  task automatic latency(output int n);
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (res_valid) break;
      @(posedge clk);
      n++;
    end
  endtask

  initial begin
    bit ok;
    int n, s0, c0, seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_c = '0;
    in_j = '0;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_g", 32'(res_g), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_eng_clr", 32'(eng_clr), 32'd0);
    chk("rst_eng_c", 32'(eng_c), 32'd0);
    chk("rst_eng_j", 32'(eng_j), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1 chk("in_ready_at_release", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
    sync();

    // Single job c=2 j=100 with a 3-cycle engine
    lat = 3;
    push(16'd2, 16'd100, 20, ok);
    chk("t1_push", 32'(ok), 32'd1);
    latency(n);
    chk("t1_latency", 32'(n), 32'd6);
    chk("t1_g", 32'(res_g), 32'd6);
    chk("t1_err", 32'(res_err), 32'd0);
    wait_idle(50);

    // Back-to-back jobs return in order
    lat = 2;
    sync();
    push(16'd3, 16'd10, 20, ok);
    push(16'd5, 16'd5, 20, ok);
    wait_res(100, ok);
    chk("t2_first_seen", 32'(ok), 32'd1);
    chk("t2_first_g", 32'(res_g), 32'd2);
    sync();
    wait_res(100, ok);
    chk("t2_second_seen", 32'(ok), 32'd1);
    chk("t2_second_g", 32'(res_g), 32'd0);
    wait_idle(50);

    // Bad bases never reach the engine
    s0 = start_cycles;
    sync();
    push(16'd1, 16'd50, 20, ok);
    latency(n);
    chk("t3_latency", 32'(n), 32'd2);
    chk("t3_err_c1", 32'(res_err), 32'd1);
    chk("t3_g_c1", 32'(res_g), 32'd0);
    sync();
    push(16'd0, 16'd7, 20, ok);
    wait_res(50, ok);
    chk("t3_err_c0", 32'(res_err), 32'd1);
    wait_idle(50);
    chk("t3_no_start", 32'(start_cycles - s0), 32'd0);

    // Hung engine times out after 16 WAIT cycles, then the next job runs normally
    hang = 1'b1;
    s0 = start_cycles;
    c0 = clr_pulses;
    sync();
    push(16'd4, 16'd100, 20, ok);
    wait_res(100, ok);
    chk("t4_tmo_seen", 32'(ok), 32'd1);
    chk("t4_err", 32'(res_err), 32'd2);
    chk("t4_g", 32'(res_g), 32'd0);
    wait_idle(50);
    chk("t4_start_cycles", 32'(start_cycles - s0), 32'd17);
    chk("t4_clr_pulses", 32'(clr_pulses - c0), 32'd1);
    hang = 1'b0;
    sync();
    push(16'd3, 16'd10, 20, ok);
    wait_res(100, ok);
    chk("t4_next_g", 32'(res_g), 32'd2);
    wait_idle(50);

    // Result backpressure fills the FIFO: 1 in flight + 4 buffered
    rdy_set = 1'b0;
    lat = 2;
    sync();
    for (int i = 0; i < 5; i++) begin
      push(16'(i + 2), 16'(50 + 7 * i), 20, ok);
      chk("t5_accept", 32'(ok), 32'd1);
    end
    push(16'd7, 16'd7, 40, ok);
    chk("t5_sixth_refused", 32'(ok), 32'd0);
    chk("t5_in_ready_low", 32'(in_ready), 32'd0);
    rdy_set = 1'b1;
    wait_idle(300);
    chk("t5_all_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a WAIT aborts everything
    lat = 12;
    sync();
    push(16'd2, 16'd100, 20, ok);
    push(16'd3, 16'd10, 20, ok);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (eng_start) break;
    end
    repeat (4) @(negedge clk);
    chk("t6_in_wait", 32'(eng_start), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_start_abort", 32'(eng_start), 32'd0);
    chk("t6_res_abort", 32'(res_valid), 32'd0);
    chk("t6_fifo_flushed", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_in_ready_release", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t6_in_ready_up", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid || eng_start) seen++;
    end
    chk("t6_no_result", 32'(seen), 32'd0);

    // Random traffic with random backpressure, latency and lingering done
    rnd_rdy = 1'b1;
    sync();
    for (int i = 0; i < 80; i++) begin
      lat = $urandom_range(1, 6);
      linger = $urandom_range(0, 3);
      push(16'($urandom_range(0, 12)), 16'($urandom_range(0, 3000)), 500, ok);
      chk("rnd_push", 32'(ok), 32'd1);
      repeat ($urandom_range(0, 3)) sync();
    end
    rnd_rdy = 1'b0;
    rdy_set = 1'b1;
    wait_idle(2000);
    chk("rnd_all_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
